// File: rtl/fix_pkg.sv
// Shared constants, state encodings and helpers for the FIX receive buffer.
package fix_pkg;

    localparam int DEFAULT_DEPTH = 256;

    localparam logic [7:0] SOH      = 8'h01;
    localparam logic [7:0] ASCII_0  = 8'h30;
    localparam logic [7:0] ASCII_1  = 8'h31;
    localparam logic [7:0] ASCII_9  = 8'h39;
    localparam logic [7:0] ASCII_EQ = 8'h3D;

    typedef enum logic [2:0] {FSTART, T1, T10, TEQ, D1, D2, D3, MID} det_state_t;
    typedef enum logic [1:0] {IDLE, START, STREAM} rd_state_t;

    function automatic logic is_digit(input logic [7:0] c);
        return (c >= ASCII_0) && (c <= ASCII_9);
    endfunction

endpackage

// File: rtl/fix_trailer_detect.sv
// Spots the SOH that closes a "10=ddd" checksum field beginning at a field start.
module fix_trailer_detect
    import fix_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] data,
    input  logic       strobe,
    input  logic       clear,
    output logic       end_flag
);

    det_state_t state;

    // The flag travels with the byte being written, so it is decoded from the current state.
    assign end_flag = strobe && (data == SOH) && (state == D3);

    // NOTE: state registers use <= so every flop samples pre-edge values, avoiding sim/synth races.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= FSTART;
        end else if (clear) begin
            state <= FSTART;
        end else if (strobe) begin
            if (data == SOH) begin
                state <= FSTART;
            end else begin
                case (state)
                    FSTART:  state <= (data == ASCII_1)  ? T1  : MID;
                    T1:      state <= (data == ASCII_0)  ? T10 : MID;
                    T10:     state <= (data == ASCII_EQ) ? TEQ : MID;
                    TEQ:     state <= is_digit(data) ? D1 : MID;
                    D1:      state <= is_digit(data) ? D2 : MID;
                    D2:      state <= is_digit(data) ? D3 : MID;
                    default: state <= MID;
                endcase
            end
        end
    end

endmodule

// File: rtl/fix_rx_buffer.sv
// Byte FIFO between the TCP offload engine and the FIX engine; releases only whole messages.
module fix_rx_buffer
    import fix_pkg::*;
#(
    parameter int DEPTH = DEFAULT_DEPTH
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [7:0]               toe_data_i,
    input  logic                     toe_valid_i,
    output logic                     toe_ready_o,
    input  logic                     flush_i,
    output logic                     new_message_o,
    output logic [7:0]               message_o,
    output logic                     valid_o,
    input  logic                     ready_i,
    output logic                     last_o,
    output logic [$clog2(DEPTH):0]   msg_count_o,
    output logic                     overflow_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    logic [8:0]    mem [DEPTH];
    logic [AW:0]   wr_ptr;
    logic [AW:0]   rd_ptr;
    logic [8:0]    head;
    logic          full;
    logic          wr_en;
    logic          rd_xfer;
    logic          end_flag;
    logic          discard;
    rd_state_t     rd_state;

    assign full        = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign toe_ready_o = !full;
    assign wr_en       = toe_valid_i && toe_ready_o && !flush_i;
    // A full buffer with no complete message can never drain, so the partial message is dropped.
    assign discard     = full && (msg_count_o == '0) && !flush_i;

    assign head      = mem[rd_ptr[AW-1:0]];
    assign rd_xfer   = valid_o && ready_i;
    assign message_o = valid_o ? head[7:0] : 8'h00;
    assign last_o    = valid_o && head[8];

    fix_trailer_detect u_detect (
        .clk      (clk),
        .rst      (rst),
        .data     (toe_data_i),
        .strobe   (wr_en),
        .clear    (flush_i || discard),
        .end_flag (end_flag)
    );

    // NOTE: the storage array has no reset; the pointers alone say which entries are live.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr[AW-1:0]] <= {end_flag, toe_data_i};
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            msg_count_o <= '0;
            overflow_o  <= 1'b0;
        end else if (flush_i) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            msg_count_o <= '0;
            overflow_o  <= 1'b0;
        end else if (discard) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            overflow_o  <= 1'b1;
        end else begin
            overflow_o <= 1'b0;
            if (wr_en) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (rd_xfer) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({wr_en && end_flag, rd_xfer && last_o})
                2'b10:   msg_count_o <= msg_count_o + PW'(1);
                2'b01:   msg_count_o <= msg_count_o - PW'(1);
                default: msg_count_o <= msg_count_o;
            endcase
        end
    end

    // Streaming only begins once a message is complete, so the head is always valid in STREAM.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_state      <= IDLE;
            new_message_o <= 1'b0;
            valid_o       <= 1'b0;
        end else if (flush_i) begin
            rd_state      <= IDLE;
            new_message_o <= 1'b0;
            valid_o       <= 1'b0;
        end else begin
            case (rd_state)
                IDLE: begin
                    if (msg_count_o != '0) begin
                        rd_state      <= START;
                        new_message_o <= 1'b1;
                    end
                end
                START: begin
                    rd_state      <= STREAM;
                    new_message_o <= 1'b0;
                    valid_o       <= 1'b1;
                end
                STREAM: begin
                    if (rd_xfer && last_o) begin
                        rd_state <= IDLE;
                        valid_o  <= 1'b0;
                    end
                end
                default: begin
                    rd_state      <= IDLE;
                    new_message_o <= 1'b0;
                    valid_o       <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fix_rx_buffer.sv
// Randomised bench for fix_rx_buffer with a message-level reference model and scoreboard.
module tb_fix_rx_buffer;
    import fix_pkg::*;

    localparam int DEPTH = 256;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [7:0]    toe_data_i = 8'h00;
    logic          toe_valid_i = 1'b0;
    logic          toe_ready_o;
    logic          flush_i = 1'b0;
    logic          new_message_o;
    logic [7:0]    message_o;
    logic          valid_o;
    logic          ready_i = 1'b1;
    logic          last_o;
    logic [CW-1:0] msg_count_o;
    logic          overflow_o;

    always #5 clk = ~clk;

    fix_rx_buffer #(.DEPTH(DEPTH)) dut (
        .clk           (clk),
        .rst           (rst),
        .toe_data_i    (toe_data_i),
        .toe_valid_i   (toe_valid_i),
        .toe_ready_o   (toe_ready_o),
        .flush_i       (flush_i),
        .new_message_o (new_message_o),
        .message_o     (message_o),
        .valid_o       (valid_o),
        .ready_i       (ready_i),
        .last_o        (last_o),
        .msg_count_o   (msg_count_o),
        .overflow_o    (overflow_o)
    );

    int total = 0;
    int bad = 0;
    int rdy_mode = 0;     // 0 always ready, 1 alternate, 2 random, 3 driven by the test
    bit gap_en = 1'b0;
    int nm_count = 0;
    int ov_count = 0;
    int valid_cycles = 0;
    int xfer_count = 0;

    // Reference model: bytes of the current field, bytes of the unfinished message,
    // and the expected outbound stream {last, byte} of completed messages.
    logic [7:0] field[$];
    logic [8:0] pend[$];
    logic [8:0] exp_q[$];

    function automatic void model_clear();
        field.delete();
        pend.delete();
        exp_q.delete();
    endfunction

    function automatic void model_accept(input logic [7:0] b);
        bit done;
        if (b == 8'h01) begin
            done = (field.size() == 6) && (field[0] == 8'h31) && (field[1] == 8'h30) &&
                   (field[2] == 8'h3D);
            for (int i = 3; i < 6 && done; i++)
                done = (field[i] >= 8'h30) && (field[i] <= 8'h39);
            pend.push_back({done, b});
            field.delete();
            if (done) begin
                foreach (pend[i]) exp_q.push_back(pend[i]);
                pend.delete();
            end
        end else begin
            field.push_back(b);
            pend.push_back({1'b0, b});
        end
    endfunction

    function automatic string gen_msg();
        string s;
        s = "8=FIX.4.4|";
        for (int f = 0; f < int'($urandom_range(1, 3)); f++)
            s = {s, $sformatf("%0d=%0d|", $urandom_range(20, 99), $urandom_range(0, 99999))};
        s = {s, $sformatf("10=%03d|", $urandom_range(0, 999))};
        return s;
    endfunction

    initial forever begin
        @(posedge clk);
        #1;
        case (rdy_mode)
            0:       ready_i = 1'b1;
            1:       ready_i = !ready_i;
            2:       ready_i = 1'($urandom_range(0, 1));
            default: ;
        endcase
    end

    // Scoreboard: every transfer is matched against the model, and a stalled head must hold.
    initial begin
        logic [8:0] held, got, want;
        bit holding;
        holding = 1'b0;
        held = '0;
        forever begin
            @(negedge clk);
            got = {last_o, message_o};
            if (new_message_o) nm_count++;
            if (overflow_o) ov_count++;
            if (valid_o) valid_cycles++;
            if (holding && valid_o) begin
                total++;
                if (got !== held) begin
                    bad++;
                    $display("FAIL hold_stable: got %h want %h", got, held);
                end
            end
            if (valid_o && ready_i) begin
                xfer_count++;
                total++;
                if (exp_q.size() == 0) begin
                    bad++;
                    $display("FAIL stream_extra: got %h want no byte", got);
                end else begin
                    want = exp_q.pop_front();
                    if (got !== want) begin
                        bad++;
                        $display("FAIL stream_byte: got %h want %h", got, want);
                    end
                end
            end
            holding = valid_o && !ready_i;
            held = got;
        end
    end

    task automatic send_byte(input logic [7:0] b);
        bit acc;
        int guard;
        acc = 1'b0;
        guard = 0;
        toe_data_i = b;
        toe_valid_i = 1'b1;
        while (!acc) begin
            @(negedge clk);
            acc = toe_ready_o;
            @(posedge clk);
            #1;
            guard++;
            if (!acc && guard > 2000) begin
                total++;
                bad++;
                $display("FAIL send_timeout: got ready=0 want ready=1");
                break;
            end
        end
        toe_valid_i = 1'b0;
        if (acc) model_accept(b);
        if (gap_en) repeat ($urandom_range(0, 2)) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_str(input string s);
        logic [7:0] c;
        for (int i = 0; i < s.len(); i++) begin
            c = s.getc(i);
            if (c == "|") c = 8'h01;
            send_byte(c);
        end
    endtask

    task automatic wait_drain(input string name);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || valid_o || msg_count_o != 0) && n < 3000) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (n >= 3000) begin
            total++;
            bad++;
            $display("FAIL %s drain_timeout: got %0d bytes left want 0", name, exp_q.size());
        end
        repeat (3) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_valid(input string name);
        int n;
        n = 0;
        while (!valid_o && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        total++;
        if (!valid_o) begin
            bad++;
            $display("FAIL %s valid_timeout: got valid=0 want 1", name);
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        total += 5;
        if (msg_count_o !== '0) begin bad++; $display("FAIL reset_count: got %0d want 0", msg_count_o); end
        if (valid_o !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b want 0", valid_o); end
        if (new_message_o !== 1'b0) begin bad++; $display("FAIL reset_newmsg: got %b want 0", new_message_o); end
        if (last_o !== 1'b0) begin bad++; $display("FAIL reset_last: got %b want 0", last_o); end
        if (overflow_o !== 1'b0) begin bad++; $display("FAIL reset_overflow: got %b want 0", overflow_o); end
        rst = 1'b1;
        @(posedge clk);
        #1;
        total++;
        if (toe_ready_o !== 1'b1) begin bad++; $display("FAIL reset_ready: got %b want 1", toe_ready_o); end
    endtask

    task automatic test_single();
        int nm0, x0;
        rdy_mode = 0;
        gap_en = 1'b0;
        nm0 = nm_count;
        x0 = xfer_count;
        send_str("8=FIX.4.2|9=5|35=0|10=123");
        send_byte(8'h01);
        @(negedge clk);
        total += 2;
        if (msg_count_o !== CW'(1)) begin bad++; $display("FAIL single_count_up: got %0d want 1", msg_count_o); end
        if (new_message_o !== 1'b0) begin bad++; $display("FAIL single_newmsg_early: got %b want 0", new_message_o); end
        @(negedge clk);
        total += 2;
        if (new_message_o !== 1'b1) begin bad++; $display("FAIL single_newmsg: got %b want 1", new_message_o); end
        if (valid_o !== 1'b0) begin bad++; $display("FAIL single_valid_early: got %b want 0", valid_o); end
        @(negedge clk);
        total += 2;
        if (valid_o !== 1'b1) begin bad++; $display("FAIL single_valid: got %b want 1", valid_o); end
        if (new_message_o !== 1'b0) begin bad++; $display("FAIL single_newmsg_len: got %b want 0", new_message_o); end
        wait_drain("single");
        total += 3;
        if (xfer_count - x0 != 26) begin bad++; $display("FAIL single_bytes: got %0d want 26", xfer_count - x0); end
        if (nm_count - nm0 != 1) begin bad++; $display("FAIL single_pulses: got %0d want 1", nm_count - nm0); end
        if (msg_count_o !== '0) begin bad++; $display("FAIL single_count_down: got %0d want 0", msg_count_o); end
    endtask

    task automatic test_garbage();
        int nm0, v0;
        nm0 = nm_count;
        v0 = valid_cycles;
        send_str("35=0|110=5|10=12a|10=1234|");
        repeat (8) begin
            @(posedge clk);
            #1;
        end
        total += 3;
        if (msg_count_o !== '0) begin bad++; $display("FAIL garbage_count: got %0d want 0", msg_count_o); end
        if (nm_count != nm0) begin bad++; $display("FAIL garbage_newmsg: got %0d want 0", nm_count - nm0); end
        if (valid_cycles != v0) begin bad++; $display("FAIL garbage_valid: got %0d want 0", valid_cycles - v0); end
        flush_i = 1'b1;
        @(posedge clk);
        #1;
        flush_i = 1'b0;
        model_clear();
    endtask

    task automatic test_back_to_back();
        int nm0, x0;
        string m1, m2;
        rdy_mode = 1;
        gap_en = 1'b0;
        nm0 = nm_count;
        x0 = xfer_count;
        m1 = gen_msg();
        m2 = gen_msg();
        send_str(m1);
        send_str(m2);
        wait_drain("b2b");
        total += 2;
        if (nm_count - nm0 != 2) begin bad++; $display("FAIL b2b_pulses: got %0d want 2", nm_count - nm0); end
        if (xfer_count - x0 != m1.len() + m2.len()) begin
            bad++;
            $display("FAIL b2b_bytes: got %0d want %0d", xfer_count - x0, m1.len() + m2.len());
        end
    endtask

    task automatic test_random();
        int nm0;
        string s;
        rdy_mode = 2;
        gap_en = 1'b1;
        nm0 = nm_count;
        for (int i = 0; i < 6; i++) begin
            s = gen_msg();
            if ($urandom_range(0, 1) == 1) s = {"35=0|110=5|10=12a|", s};
            send_str(s);
        end
        wait_drain("random");
        total++;
        if (nm_count - nm0 != 6) begin bad++; $display("FAIL random_pulses: got %0d want 6", nm_count - nm0); end
        gap_en = 1'b0;
    endtask

    task automatic test_overflow();
        int ov0, nm0, v0;
        rdy_mode = 0;
        ov0 = ov_count;
        v0 = valid_cycles;
        for (int i = 0; i < DEPTH; i++) send_byte(8'h41);
        model_clear();
        repeat (6) begin
            @(posedge clk);
            #1;
        end
        total += 4;
        if (ov_count - ov0 != 1) begin bad++; $display("FAIL ovf_pulse: got %0d want 1", ov_count - ov0); end
        if (msg_count_o !== '0) begin bad++; $display("FAIL ovf_count: got %0d want 0", msg_count_o); end
        if (toe_ready_o !== 1'b1) begin bad++; $display("FAIL ovf_empty: got ready=%b want 1", toe_ready_o); end
        if (valid_cycles != v0) begin bad++; $display("FAIL ovf_valid: got %0d want 0", valid_cycles - v0); end
        nm0 = nm_count;
        send_str(gen_msg());
        wait_drain("ovf_after");
        total++;
        if (nm_count - nm0 != 1) begin bad++; $display("FAIL ovf_after_pulses: got %0d want 1", nm_count - nm0); end
    endtask

    task automatic test_concurrent();
        int nm0;
        string m1, m2;
        rdy_mode = 3;
        ready_i = 1'b0;
        nm0 = nm_count;
        m1 = gen_msg();
        m2 = gen_msg();
        send_str(m1);
        send_str(m2.substr(0, m2.len() - 2));
        wait_valid("conc");
        ready_i = 1'b1;
        repeat (m1.len() - 1) begin
            @(posedge clk);
            #1;
        end
        toe_data_i = 8'h01;
        toe_valid_i = 1'b1;
        @(negedge clk);
        total++;
        if (!(valid_o && last_o && toe_ready_o)) begin
            bad++;
            $display("FAIL conc_align: got valid=%b last=%b ready=%b want 1 1 1", valid_o, last_o, toe_ready_o);
        end
        @(posedge clk);
        #1;
        toe_valid_i = 1'b0;
        model_accept(8'h01);
        @(negedge clk);
        total++;
        if (msg_count_o !== CW'(1)) begin bad++; $display("FAIL conc_count: got %0d want 1", msg_count_o); end
        @(posedge clk);
        #1;
        rdy_mode = 0;
        wait_drain("conc");
        total++;
        if (nm_count - nm0 != 2) begin bad++; $display("FAIL conc_pulses: got %0d want 2", nm_count - nm0); end
    endtask

    task automatic test_reset_flush();
        int nm0;
        rdy_mode = 1;
        send_str(gen_msg());
        wait_valid("rstflush");
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        rst = 1'b0;
        #1;
        model_clear();
        total += 5;
        if (msg_count_o !== '0) begin bad++; $display("FAIL midrst_count: got %0d want 0", msg_count_o); end
        if (valid_o !== 1'b0) begin bad++; $display("FAIL midrst_valid: got %b want 0", valid_o); end
        if (new_message_o !== 1'b0) begin bad++; $display("FAIL midrst_newmsg: got %b want 0", new_message_o); end
        if (last_o !== 1'b0) begin bad++; $display("FAIL midrst_last: got %b want 0", last_o); end
        if (overflow_o !== 1'b0) begin bad++; $display("FAIL midrst_overflow: got %b want 0", overflow_o); end
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rdy_mode = 0;
        send_str("8=FIX.4.4|35=A|");
        toe_data_i = 8'h39;
        toe_valid_i = 1'b1;
        flush_i = 1'b1;
        @(posedge clk);
        #1;
        flush_i = 1'b0;
        toe_valid_i = 1'b0;
        model_clear();
        @(negedge clk);
        total += 3;
        if (msg_count_o !== '0) begin bad++; $display("FAIL flush_count: got %0d want 0", msg_count_o); end
        if (valid_o !== 1'b0) begin bad++; $display("FAIL flush_valid: got %b want 0", valid_o); end
        if (toe_ready_o !== 1'b1) begin bad++; $display("FAIL flush_ready: got %b want 1", toe_ready_o); end
        @(posedge clk);
        #1;
        nm0 = nm_count;
        send_str(gen_msg());
        wait_drain("after_flush");
        total++;
        if (nm_count - nm0 != 1) begin bad++; $display("FAIL flush_after_pulses: got %0d want 1", nm_count - nm0); end
    endtask

    initial begin
        #800000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_single();
        test_garbage();
        test_back_to_back();
        test_random();
        test_overflow();
        test_concurrent();
        test_reset_flush();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
